float_add_prep: RTL

Operand-preparation stage placed directly upstream of the 12-bit float adder. It accepts two 12-bit floats through a valid/ready handshake and registers them over two pipeline stages. It orders the operands so the larger magnitude is on x_out, which the adder requires because it computes x exponent minus y exponent. It also raises flags for conditions the adder cannot handle: negative sign, exponent difference of 8 or more, and exponent carry risk.

---
 rtl/float_add_prep.sv | 89 ++++++++
 1 files changed

// File: rtl/float_add_prep.sv
// rtl/float_add_prep.sv - operand ordering and hazard-flag stage ahead of the 12-bit float adder
module float_add_prep #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     x_out,
  output logic [EXP_W+MAN_W:0]     y_out,
  output logic                     swapped,
  output logic                     sign_err,
  output logic                     far_flag,
  output logic                     ovf_risk
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = EXP_W + MAN_W;

  logic          s1_valid, s2_valid;
  logic          s1_adv, s2_adv;
  logic [W-1:0]  s1_a, s1_b;

  logic [MW-1:0]    mag_a, mag_b, x_mag, y_mag;
  logic [EXP_W-1:0] x_exp, y_exp, diff;
  logic             swap;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Magnitude order on {exp, man}; ties keep a on x so swapped only marks a strict win by b.
  always_comb begin
    mag_a = s1_a[MW-1:0];
    mag_b = s1_b[MW-1:0];
    swap  = mag_b > mag_a;
    x_mag = swap ? mag_b : mag_a;
    y_mag = swap ? mag_a : mag_b;
    x_exp = x_mag[MW-1:MAN_W];
    y_exp = y_mag[MW-1:MAN_W];
    diff  = x_exp - y_exp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      swapped  <= 1'b0;
      sign_err <= 1'b0;
      far_flag <= 1'b0;
      ovf_risk <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        x_out    <= {1'b0, x_mag};
        y_out    <= {1'b0, y_mag};
        swapped  <= swap;
        sign_err <= s1_a[W-1] | s1_b[W-1];
        far_flag <= diff >= EXP_W'(8);
        ovf_risk <= x_exp == '1;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
